// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the L2 tag-RAM arbiter.
// Contents: FSM state encoding, thread op codes, access source
// encoding, a one-hot way decoder and the tree-PLRU victim function.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OP_LOOKUP = 1'b0,
    OP_WB     = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_THR  = 2'd1,
    SRC_MEM  = 2'd2
  } src_t;

  function automatic logic [3:0] onehot4(input logic [1:0] way);
    return 4'b0001 << way;
  endfunction

  // Tree PLRU: bit0 picks the half, bit1/bit2 pick inside the low/high half.
  function automatic logic [1:0] plru_victim(input logic [2:0] plru);
    if (plru[0]) return plru[2] ? 2'd3 : 2'd2;
    else         return plru[1] ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/l2_rr_arb4.sv
// Combinational 4-input round-robin picker.
// Ports: req  - request vector
//        ptr  - highest-priority requester this round
//        gnt  - one-hot winner (zero when nothing requests)
//        valid- any request present
module l2_rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       valid
);

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] win;

  // Rotate so that req[ptr] lands at bit 0, take the lowest set bit,
  // then rotate the winner back; the 2-bit add gives the 3->0 wrap.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[3:0];
    off   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) off = 2'(k);
    end
    win   = ptr + off;
    valid = |req;
    gnt   = valid ? (4'b0001 << win) : 4'b0000;
  end

endmodule

// File: rtl/l2_tag_arb.sv
// Arbiter/sequencer for the shared 4-way L2 tag/PLRU/dirty/thread RAM port.
// Four per-thread L1 requesters (lookup or writeback) and the memory refill
// path compete; each granted access drives the RAM strobes for two cycles,
// then a RESP cycle pulses done (visible the cycle after) and, for lookups,
// latches tags, dirty bits and the PLRU victim.
// Ports: clk/rst (async, active-low); thr_* per-thread request bundle;
//        mem_* refill request bundle; tag_rd/plru_rd/dirty_rd RAM read data;
//        thr_gnt/mem_gnt and thr_done/mem_done pulses; blk_*/wd_*/index_*/
//        tag_wd_*/thread_* RAM control; rsp_tags/rsp_dirty/victim_way results.
module l2_tag_arb
  import l2_arb_pkg::*;
#(
  parameter int MEM_MAX_CONSEC = 4,
  parameter int IDX_W          = 9,
  parameter int TAG_W          = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           thr_req,
  input  logic [3:0]           thr_op,
  input  logic [4*IDX_W-1:0]   thr_index,
  input  logic [7:0]           thr_way,
  input  logic [4*TAG_W-1:0]   thr_tag,
  input  logic                 mem_req,
  input  logic [IDX_W-1:0]     mem_index,
  input  logic [1:0]           mem_way,
  input  logic [TAG_W-1:0]     mem_tag,
  input  logic [1:0]           mem_thread,
  input  logic [4*TAG_W-1:0]   tag_rd,
  input  logic [2:0]           plru_rd,
  input  logic [3:0]           dirty_rd,
  output logic [3:0]           thr_gnt,
  output logic                 mem_gnt,
  output logic [3:0]           thr_done,
  output logic                 mem_done,
  output logic [3:0]           blk_re,
  output logic [3:0]           blk_we_l2,
  output logic [3:0]           blk_we_mem,
  output logic                 wd_from_l1_en,
  output logic                 wd_from_mem_en,
  output logic [IDX_W-1:0]     index_l2,
  output logic [IDX_W-1:0]     index_mem,
  output logic [TAG_W-1:0]     tag_wd_l2,
  output logic [TAG_W-1:0]     tag_wd_mem,
  output logic [1:0]           thread_l2,
  output logic [1:0]           thread_mem,
  output logic [4*TAG_W-1:0]   rsp_tags,
  output logic [3:0]           rsp_dirty,
  output logic [1:0]           victim_way
);

  localparam int              CNT_W   = $clog2(MEM_MAX_CONSEC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_MAX_CONSEC);

  state_t           state;
  src_t             cur_src;
  op_t              cur_op;
  logic [1:0]       cur_thr;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] mem_cnt;

  logic [3:0] rr_gnt;
  logic       rr_valid;
  logic [1:0] win;
  logic       thr_pend;
  logic       mem_ok;
  logic       grant_mem;
  logic       grant_thr;

  l2_rr_arb4 u_rr (
    .req   (thr_req),
    .ptr   (ptr),
    .gnt   (rr_gnt),
    .valid (rr_valid)
  );

  always_comb begin
    win = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rr_gnt[i]) win = 2'(i);
    end
  end

  // Memory wins ties unless it has already taken MEM_MAX_CONSEC grants in a
  // row while threads were waiting.
  assign thr_pend  = |thr_req;
  assign mem_ok    = mem_req && (!thr_pend || (mem_cnt < CNT_MAX));
  assign grant_mem = (state == ST_IDLE) && mem_ok;
  assign grant_thr = (state == ST_IDLE) && !mem_ok && rr_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cur_src        <= SRC_NONE;
      cur_op         <= OP_LOOKUP;
      cur_thr        <= 2'd0;
      ptr            <= 2'd0;
      mem_cnt        <= '0;
      thr_gnt        <= 4'd0;
      mem_gnt        <= 1'b0;
      thr_done       <= 4'd0;
      mem_done       <= 1'b0;
      blk_re         <= 4'd0;
      blk_we_l2      <= 4'd0;
      blk_we_mem     <= 4'd0;
      wd_from_l1_en  <= 1'b0;
      wd_from_mem_en <= 1'b0;
      index_l2       <= '0;
      index_mem      <= '0;
      tag_wd_l2      <= '0;
      tag_wd_mem     <= '0;
      thread_l2      <= 2'd0;
      thread_mem     <= 2'd0;
      rsp_tags       <= '0;
      rsp_dirty      <= 4'd0;
      victim_way     <= 2'd0;
    end else begin
      thr_gnt  <= 4'd0;
      mem_gnt  <= 1'b0;
      thr_done <= 4'd0;
      mem_done <= 1'b0;

      if (grant_mem && thr_pend) begin
        mem_cnt <= (mem_cnt == CNT_MAX) ? CNT_MAX : mem_cnt + 1'b1;
      end else if (grant_thr || !thr_pend) begin
        mem_cnt <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (grant_mem) begin
            state          <= ST_ACC1;
            cur_src        <= SRC_MEM;
            mem_gnt        <= 1'b1;
            wd_from_mem_en <= 1'b1;
            blk_we_mem     <= onehot4(mem_way);
            index_mem      <= mem_index;
            tag_wd_mem     <= mem_tag;
            thread_mem     <= mem_thread;
          end else if (grant_thr) begin
            state     <= ST_ACC1;
            cur_src   <= SRC_THR;
            cur_op    <= op_t'(thr_op[win]);
            cur_thr   <= win;
            ptr       <= win + 2'd1;
            thr_gnt   <= rr_gnt;
            index_l2  <= thr_index[win*IDX_W +: IDX_W];
            thread_l2 <= win;
            if (thr_op[win] == OP_WB) begin
              wd_from_l1_en <= 1'b1;
              blk_we_l2     <= onehot4(thr_way[win*2 +: 2]);
              tag_wd_l2     <= thr_tag[win*TAG_W +: TAG_W];
            end else begin
              blk_re <= 4'hF;
            end
          end
        end
        ST_ACC1: state <= ST_ACC2;
        ST_ACC2: begin
          state          <= ST_RESP;
          blk_re         <= 4'd0;
          blk_we_l2      <= 4'd0;
          blk_we_mem     <= 4'd0;
          wd_from_l1_en  <= 1'b0;
          wd_from_mem_en <= 1'b0;
          index_l2       <= '0;
          index_mem      <= '0;
          tag_wd_l2      <= '0;
          tag_wd_mem     <= '0;
          thread_l2      <= 2'd0;
          thread_mem     <= 2'd0;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (cur_src == SRC_MEM) mem_done <= 1'b1;
          else                    thr_done <= onehot4(cur_thr);
          if (cur_src == SRC_THR && cur_op == OP_LOOKUP) begin
            rsp_tags   <= tag_rd;
            rsp_dirty  <= dirty_rd;
            victim_way <= plru_victim(plru_rd);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_tag_arb.sv
// Self-checking bench for l2_tag_arb: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model that
// counts cycles since each grant.
module tb_l2_tag_arb;

  localparam int IDX_W = 9;
  localparam int TAG_W = 18;
  localparam int MAXC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [3:0]         thr_req = '0;
  logic [3:0]         thr_op;
  logic [4*IDX_W-1:0] thr_index;
  logic [7:0]         thr_way;
  logic [4*TAG_W-1:0] thr_tag;
  logic               mem_req = 1'b0;
  logic [IDX_W-1:0]   mem_index = '0;
  logic [1:0]         mem_way = '0;
  logic [TAG_W-1:0]   mem_tag = '0;
  logic [1:0]         mem_thread = '0;
  logic [4*TAG_W-1:0] tag_rd = '0;
  logic [2:0]         plru_rd = '0;
  logic [3:0]         dirty_rd = '0;

  logic [3:0]         thr_gnt, thr_done, blk_re, blk_we_l2, blk_we_mem, rsp_dirty;
  logic               mem_gnt, mem_done, wd_from_l1_en, wd_from_mem_en;
  logic [IDX_W-1:0]   index_l2, index_mem;
  logic [TAG_W-1:0]   tag_wd_l2, tag_wd_mem;
  logic [1:0]         thread_l2, thread_mem, victim_way;
  logic [4*TAG_W-1:0] rsp_tags;

  logic             t_op [4] = '{default: 1'b0};
  logic [IDX_W-1:0] t_idx[4] = '{default: '0};
  logic [1:0]       t_way[4] = '{default: '0};
  logic [TAG_W-1:0] t_tag[4] = '{default: '0};

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign thr_op[g]                  = t_op[g];
    assign thr_index[g*IDX_W +: IDX_W] = t_idx[g];
    assign thr_way[g*2 +: 2]          = t_way[g];
    assign thr_tag[g*TAG_W +: TAG_W]  = t_tag[g];
  end

  l2_tag_arb dut (
    .clk(clk), .rst(rst),
    .thr_req(thr_req), .thr_op(thr_op), .thr_index(thr_index), .thr_way(thr_way),
    .thr_tag(thr_tag), .mem_req(mem_req), .mem_index(mem_index), .mem_way(mem_way),
    .mem_tag(mem_tag), .mem_thread(mem_thread), .tag_rd(tag_rd), .plru_rd(plru_rd),
    .dirty_rd(dirty_rd), .thr_gnt(thr_gnt), .mem_gnt(mem_gnt), .thr_done(thr_done),
    .mem_done(mem_done), .blk_re(blk_re), .blk_we_l2(blk_we_l2), .blk_we_mem(blk_we_mem),
    .wd_from_l1_en(wd_from_l1_en), .wd_from_mem_en(wd_from_mem_en),
    .index_l2(index_l2), .index_mem(index_mem), .tag_wd_l2(tag_wd_l2),
    .tag_wd_mem(tag_wd_mem), .thread_l2(thread_l2), .thread_mem(thread_mem),
    .rsp_tags(rsp_tags), .rsp_dirty(rsp_dirty), .victim_way(victim_way)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: m_ph = cycles since the current grant (0 = idle,
  // 1..2 = strobes, 3 = response cycle, 4 = done visible, arbiter free).
  int               m_ph, m_src, m_ptr, m_cnt;
  logic             m_op;
  logic [IDX_W-1:0] m_idx;
  logic [1:0]       m_way, m_thr;
  logic [TAG_W-1:0] m_tag;
  logic [4*TAG_W-1:0] e_tags;
  logic [3:0]       e_dirty;
  logic [1:0]       e_vict;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] victimOf(input logic [2:0] p);
    return {p[0], p[0] ? p[2] : p[1]};
  endfunction

  task automatic modelReset();
    m_ph = 0; m_src = 0; m_ptr = 0; m_cnt = 0; m_op = 0;
    m_idx = '0; m_way = '0; m_thr = '0; m_tag = '0;
    e_tags = '0; e_dirty = '0; e_vict = '0;
  endtask

  // Advances the model across the coming rising edge using current inputs.
  task automatic modelStep();
    bit pend;
    int gsrc;
    pend = (thr_req != 4'd0);
    gsrc = -1;
    if (m_ph == 0 || m_ph == 4) begin
      if (mem_req && (!pend || m_cnt < MAXC)) gsrc = 4;
      else if (pend) begin
        for (int k = 0; k < 4; k++)
          if (gsrc < 0 && thr_req[(m_ptr + k) % 4]) gsrc = (m_ptr + k) % 4;
      end
      if (gsrc == 4) begin
        m_ph = 1; m_src = 4; m_idx = mem_index; m_way = mem_way;
        m_tag = mem_tag; m_thr = mem_thread;
      end else if (gsrc >= 0) begin
        m_ph = 1; m_src = gsrc; m_op = t_op[gsrc]; m_idx = t_idx[gsrc];
        m_way = t_way[gsrc]; m_tag = t_tag[gsrc]; m_thr = 2'(gsrc);
        m_ptr = (gsrc + 1) % 4;
      end else m_ph = 0;
    end else begin
      if (m_ph == 3 && m_src < 4 && m_op == 1'b0) begin
        e_tags = tag_rd; e_dirty = dirty_rd; e_vict = victimOf(plru_rd);
      end
      m_ph++;
    end
    if (gsrc == 4 && pend) m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
    else if ((gsrc >= 0 && gsrc < 4) || !pend) m_cnt = 0;
  endtask

  task automatic checkOutput();
    logic [3:0] eg, ed, ere, ewl, ewm;
    logic emg, emd, el1, emem;
    logic [IDX_W-1:0] eil2, eimem;
    logic [TAG_W-1:0] etl2, etmem;
    logic [1:0] ethl2, ethm;
    eg = 0; ed = 0; ere = 0; ewl = 0; ewm = 0; emg = 0; emd = 0; el1 = 0; emem = 0;
    eil2 = 0; eimem = 0; etl2 = 0; etmem = 0; ethl2 = 0; ethm = 0;
    if (m_ph == 1) begin
      if (m_src == 4) emg = 1'b1; else eg = 4'(1 << m_src);
    end
    if (m_ph == 1 || m_ph == 2) begin
      if (m_src == 4) begin
        emem = 1'b1; ewm = 4'(1 << m_way); eimem = m_idx; etmem = m_tag; ethm = m_thr;
      end else begin
        eil2 = m_idx; ethl2 = m_thr;
        if (m_op) begin el1 = 1'b1; ewl = 4'(1 << m_way); etl2 = m_tag; end
        else ere = 4'hF;
      end
    end
    if (m_ph == 4) begin
      if (m_src == 4) emd = 1'b1; else ed = 4'(1 << m_src);
    end
    chk("thr_gnt",    128'(thr_gnt),    128'(eg));
    chk("mem_gnt",    128'(mem_gnt),    128'(emg));
    chk("thr_done",   128'(thr_done),   128'(ed));
    chk("mem_done",   128'(mem_done),   128'(emd));
    chk("blk_re",     128'(blk_re),     128'(ere));
    chk("blk_we_l2",  128'(blk_we_l2),  128'(ewl));
    chk("blk_we_mem", 128'(blk_we_mem), 128'(ewm));
    chk("wd_en",      128'({wd_from_l1_en, wd_from_mem_en}), 128'({el1, emem}));
    chk("src_excl",   128'(wd_from_l1_en & wd_from_mem_en), 128'(0));
    chk("l2_bus",     128'({index_l2, thread_l2, tag_wd_l2}), 128'({eil2, ethl2, etl2}));
    chk("mem_bus",    128'({index_mem, thread_mem, tag_wd_mem}), 128'({eimem, ethm, etmem}));
    chk("rsp",        128'({rsp_tags, rsp_dirty, victim_way}), 128'({e_tags, e_dirty, e_vict}));
  endtask

  // One clock: model across the edge, check at the following falling edge,
  // then withdraw the request that was just accepted.
  task automatic stepCycle();
    modelStep();
    @(negedge clk);
    checkOutput();
    if (m_ph == 1) begin
      if (m_src == 4) mem_req = 1'b0; else thr_req[m_src] = 1'b0;
    end
  endtask

  task automatic drain();
    thr_req = '0; mem_req = 1'b0;
    for (int i = 0; i < 8; i++) if (m_ph != 0) stepCycle();
  endtask

  task automatic applyStimulus();
    tag_rd   = 72'({$urandom(), $urandom(), $urandom()});
    plru_rd  = 3'($urandom());
    dirty_rd = 4'($urandom());
    for (int i = 0; i < 4; i++) begin
      if (!thr_req[i] && $urandom_range(3) == 0) begin
        thr_req[i] = 1'b1;
        t_op[i]  = 1'($urandom());
        t_idx[i] = IDX_W'($urandom());
        t_way[i] = 2'($urandom());
        t_tag[i] = TAG_W'($urandom());
      end else if (thr_req[i] && $urandom_range(31) == 0) thr_req[i] = 1'b0;
    end
    if (!mem_req && $urandom_range(2) == 0) begin
      mem_req    = 1'b1;
      mem_index  = IDX_W'($urandom());
      mem_way    = 2'($urandom());
      mem_tag    = TAG_W'($urandom());
      mem_thread = 2'($urandom());
    end else if (mem_req && $urandom_range(31) == 0) mem_req = 1'b0;
  endtask

  initial begin
    int got[$];
    int seen3;
    int exp_starve[6];
    int exp_rr[5];
    exp_starve = '{4, 4, 4, 4, 0, 4};
    exp_rr     = '{0, 1, 2, 3, 0};
    modelReset();

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput();
    rst = 1'b1;

    // Single lookup, thread2
    tag_rd = 72'h123456789ABCDEF012; dirty_rd = 4'b1010; plru_rd = 3'b101;
    t_op[2] = 1'b0; t_idx[2] = 9'h1A5; thr_req = 4'b0100;
    stepCycle();
    chk("lookup_gnt", 128'(thr_gnt), 128'(4'b0100));
    chk("lookup_idx", 128'(index_l2), 128'(9'h1A5));
    repeat (3) stepCycle();
    chk("lookup_done",   128'(thr_done), 128'(4'b0100));
    chk("lookup_victim", 128'(victim_way), 128'(2'd3));
    chk("lookup_dirty",  128'(rsp_dirty), 128'(4'b1010));
    drain();

    // Writeback thread1 concurrent with refill
    t_op[1] = 1'b1; t_way[1] = 2'd2; t_tag[1] = 18'h3FFFF; t_idx[1] = 9'h055;
    mem_way = 2'd0; mem_index = 9'h0F0; mem_tag = 18'h01234; mem_thread = 2'd1;
    thr_req = 4'b0010; mem_req = 1'b1;
    stepCycle();
    chk("refill_first", 128'({mem_gnt, wd_from_mem_en, blk_we_mem}), 128'({1'b1, 1'b1, 4'b0001}));
    repeat (4) stepCycle();
    chk("wb_second", 128'({thr_gnt, wd_from_l1_en, blk_we_l2}), 128'({4'b0010, 1'b1, 4'b0100}));
    drain();

    // Memory starvation limit
    got.delete();
    t_op[0] = 1'b0; thr_req = 4'b0001; mem_req = 1'b1;
    for (int c = 0; c < 28; c++) begin
      stepCycle();
      if (mem_gnt) got.push_back(4);
      for (int i = 0; i < 4; i++) if (thr_gnt[i]) got.push_back(i);
      mem_req = 1'b1;
    end
    for (int k = 0; k < 6; k++)
      chk($sformatf("starve_seq%0d", k), 128'(got.size() > k ? got[k] : 99), 128'(exp_starve[k]));
    drain();

    // Thread3 pulses for one cycle while busy
    seen3 = 0;
    mem_req = 1'b1;
    stepCycle();
    t_op[3] = 1'b0; thr_req[3] = 1'b1;
    stepCycle();
    seen3 += int'(thr_gnt[3]) + int'(thr_done[3]);
    thr_req[3] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      seen3 += int'(thr_gnt[3]) + int'(thr_done[3]);
    end
    chk("pulse_t3", 128'(seen3), 128'(0));
    drain();

    // Reset during ACC2 of a writeback
    t_op[1] = 1'b1; t_way[1] = 2'd3; thr_req = 4'b0010;
    stepCycle();
    stepCycle();
    #2 rst = 1'b0;
    #1 modelReset();
    chk("rst_strobes", 128'({blk_we_l2, wd_from_l1_en}), 128'(0));
    checkOutput();
    repeat (2) begin
      @(negedge clk);
      checkOutput();
    end
    rst = 1'b1;

    // All four threads continuously: pointer restarts at thread0
    got.delete();
    for (int i = 0; i < 4; i++) begin t_op[i] = 1'b0; t_idx[i] = IDX_W'(i * 7); end
    thr_req = 4'hF;
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      for (int i = 0; i < 4; i++) if (thr_gnt[i]) got.push_back(i);
      thr_req = 4'hF;
    end
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_seq%0d", k), 128'(got.size() > k ? got[k] : 99), 128'(exp_rr[k]));
    drain();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      stepCycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_tag_arb.md
Name: l2_tag_arb

Overview:
- Arbiter and sequencer for the 4-way L2 tag/PLRU/dirty/thread RAM block.
- Shares the single tag-RAM port between four per-thread L1 requesters (lookup or dirty writeback) and the memory refill path.
- Runs each granted access as a fixed 2-cycle RAM operation, then pulses a per-requester done.
- On lookups, it latches read data and the tree-PLRU victim way.

Parameters:
- MEM_MAX_CONSEC, 4: maximum back-to-back memory grants while any thread request is pending.
- IDX_W, 9: tag-RAM index width.
- TAG_W, 18: tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- thr_req  in  4  per-thread request; held until the matching thr_gnt bit.
- thr_op  in  4  per-thread op: 0 = lookup read, 1 = L1 writeback.
- thr_index  in  4*IDX_W  per-thread index, packed thread0 in LSBs.
- thr_way  in  8  per-thread target way for writeback, 2 bits per thread.
- thr_tag  in  4*TAG_W  per-thread tag write data.
- mem_req  in  1  refill request; held until mem_gnt.
- mem_index  in  IDX_W  refill index.
- mem_way  in  2  refill way.
- mem_tag  in  TAG_W  refill tag.
- mem_thread  in  2  refill owner thread.
- tag_rd  in  4*TAG_W  tag RAM read data, ways 0..3.
- plru_rd  in  3  PLRU read data.
- dirty_rd  in  4  per-way dirty read data.
- thr_gnt  out  4  one-hot acceptance pulse.
- mem_gnt  out  1  acceptance pulse.
- thr_done  out  4  one-hot completion pulse.
- mem_done  out  1  completion pulse.
- blk_re  out  4  per-way read strobes.
- blk_we_l2  out  4  L1-sourced write strobes.
- blk_we_mem  out  4  memory-sourced write strobes.
- wd_from_l1_en  out  1  L1 write source select.
- wd_from_mem_en  out  1  memory write source select.
- index_l2  out  IDX_W  index for the L1 source.
- index_mem  out  IDX_W  index for the memory source.
- tag_wd_l2  out  TAG_W  L1 tag write data.
- tag_wd_mem  out  TAG_W  memory tag write data.
- thread_l2  out  2  thread id for the L1 source.
- thread_mem  out  2  thread id for the memory source.
- rsp_tags  out  4*TAG_W  latched lookup tags.
- rsp_dirty  out  4  latched dirty bits.
- victim_way  out  2  latched PLRU victim.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; all outputs 0.
  - Round-robin pointer = thread0; consecutive-memory counter = 0.
  - Reset during ACC1/ACC2 drops all strobes immediately; no done pulse is issued for the aborted access.
- FSM states: IDLE -> ACC1 -> ACC2 -> RESP -> IDLE.
- IDLE:
  - If mem_req and (no thr_req pending or mem count < MEM_MAX_CONSEC): grant memory.
  - Else if any thr_req: grant the round-robin winner, searching from the pointer upward with wrap 3->0.
  - The grant pulse is registered, 1 cycle wide, in the cycle the state enters ACC1.
  - The winner's op, index, way, tag and thread are latched on grant.
- Memory-count rules:
  - Increments on each memory grant while a thread request is pending.
  - Clears on any thread grant or when no thread is pending.
  - Saturates at MEM_MAX_CONSEC.
- Pointer rule: on a thread grant, the pointer moves to winner+1 mod 4; memory grants leave it unchanged.
- ACC1 and ACC2: strobes are held stable for exactly 2 cycles.
  - Lookup: blk_re = 4'b1111; index_l2 / thread_l2 driven; wd_* = 0.
  - Writeback: wd_from_l1_en = 1; blk_we_l2 = one-hot(thr_way); tag_wd_l2 driven.
  - Refill: wd_from_mem_en = 1; blk_we_mem = one-hot(mem_way); index_mem / tag_wd_mem / thread_mem driven.
  - wd_from_l1_en and wd_from_mem_en are never both 1.
- RESP:
  - Pulse thr_done[winner] or mem_done for 1 cycle.
  - Lookup only: capture rsp_tags, rsp_dirty and victim_way.
  - victim_way = plru_rd[0] ? (plru_rd[2] ? 3 : 2) : (plru_rd[1] ? 1 : 0).
  - rsp_* hold until the next lookup RESP.
- Latency: request seen in IDLE -> grant at +1 cycle, done at +4 cycles. Back-to-back throughput is 1 access per 4 cycles.
- No new grant is issued while not in IDLE; requests arriving mid-access wait.
- A request dropped before its grant is legal and is simply not served.
- Simultaneous mem_req and thr_req: memory wins subject to the starvation limit.

Decomposition:
- Package l2_arb_pkg holds:
  - state encoding (IDLE, ACC1, ACC2, RESP);
  - op codes OP_LOOKUP / OP_WB;
  - source encodings;
  - the PLRU victim function.
- Sub-module l2_rr_arb4: combinational 4-input round-robin pick.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt one-hot, valid.
  - Instantiated once.

Test Plan:
- Single lookup, thread2, index 0x1A5:
  - thr_gnt = 0100 at +1.
  - blk_re = 1111 for exactly 2 cycles with index_l2 = 0x1A5.
  - thr_done = 0100 at +4.
  - With plru_rd = 3'b101: victim_way = 3.
- All 4 threads request continuously:
  - Grants in order 0, 1, 2, 3, 0, each 4 cycles apart.
  - Each thr_done one-hot; no overlap.
- Writeback thread1 (way 2, tag 0x3FFFF) concurrent with refill (mem_way 0):
  - Memory is granted first: blk_we_mem = 0001 with wd_from_mem_en = 1.
  - Then blk_we_l2 = 0100 with wd_from_l1_en = 1.
  - The two source enables are never high together.
- mem_req held continuously with thr_req[0] = 1:
  - Exactly 4 memory grants, then thread0 is granted, then memory resumes.
- Assert rst = 0 during ACC2 of a writeback:
  - All strobes 0 in the same cycle; no thr_done.
  - After release: state IDLE and pointer = 0.
- thr_req[3] pulsed for 1 cycle while the FSM is busy:
  - No grant and no done for thread3.
